// File: rtl/mul_pipe.sv
// mul_pipe: two-stage pipelined wrapper around the combinational multiplier `mul`
// in the EX->MEM path. S1 registers operands and drives the multiplier; S2
// captures the selected 32-bit result word for mul.w / mulh.w / mulh.wu.
// Optional build macro: MUL_PIPE_REG_READY_EN (in_ready without a
// combinational path from out_ready).
module mul_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic [4:0]  in_dest,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    output logic        mul_resetn,
    input  logic [63:0] mul_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_dest
);

    localparam logic [1:0] OP_MUL_W   = 2'b00;
    localparam logic [1:0] OP_MULH_W  = 2'b01;
    localparam logic [1:0] OP_MULH_WU = 2'b10;

    logic        s1_v;
    logic [1:0]  s1_op;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic [4:0]  s1_dest;

    logic        s2_v;
    logic [4:0]  s2_dest;
    logic [31:0] s2_res;

    logic        s2_free;
    logic        s1_adv;
    logic        in_fire;
    logic [31:0] sel_res;

    assign s2_free = ~s2_v | out_ready;
    assign s1_adv  = s1_v & s2_free;

`ifdef MUL_PIPE_REG_READY_EN
    // Ready depends only on stage occupancy; a full pipe costs one bubble.
    assign in_ready = ~flush & ~reset & ~(s1_v & s2_v);
`else
    // Ready looks through out_ready so a draining pipe keeps 1 op/cycle.
    assign in_ready = ~flush & ~reset & (~s1_v | s2_free);
`endif

    assign in_fire = in_valid & in_ready;

    assign mul_a      = s1_a;
    assign mul_b      = s1_b;
    assign mul_signed = (s1_op == OP_MULH_W);
    assign mul_resetn = ~reset;

    assign out_valid  = s2_v;
    assign out_result = s2_res;
    assign out_dest   = s2_dest;

    // Pick the architectural word out of the 64-bit product for the op in S1.
    always_comb begin
        sel_res = 32'h0;
        case (s1_op)
            OP_MUL_W:   sel_res = mul_result[31:0];
            OP_MULH_W:  sel_res = mul_result[63:32];
            OP_MULH_WU: sel_res = mul_result[63:32];
            default:    sel_res = 32'h0;
        endcase
    end

    // Operand stage: load on input transfer, empty when it advances unrefilled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v    <= 1'b0;
            s1_op   <= 2'b00;
            s1_a    <= 32'h0;
            s1_b    <= 32'h0;
            s1_dest <= 5'h0;
        end else if (flush) begin
            s1_v <= 1'b0;
        end else if (in_fire) begin
            s1_v    <= 1'b1;
            s1_op   <= in_op;
            s1_a    <= in_src1;
            s1_b    <= in_src2;
            s1_dest <= in_dest;
        end else if (s1_adv) begin
            s1_v <= 1'b0;
        end
    end

    // Result stage: capture on S1 advance, hold while MEM stalls, empty on consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_v    <= 1'b0;
            s2_dest <= 5'h0;
            s2_res  <= 32'h0;
        end else if (flush) begin
            s2_v <= 1'b0;
        end else if (s1_adv) begin
            s2_v    <= 1'b1;
            s2_dest <= s1_dest;
            s2_res  <= sel_res;
        end else if (out_ready) begin
            s2_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed stimulus with a scoreboard queue for mul_pipe; the
// bench supplies a behavioural model of the combinational multiplier `mul`.
module tb_mul_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [4:0]  in_dest;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;
    logic        mul_resetn;
    logic [63:0] mul_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;

    int checks = 0;
    int errors = 0;

    logic [36:0] sbq[$];
    logic [4:0]  cur_dest;
    logic [31:0] cur_exp;
    logic        ir_s, ov_s, acc_s;
    logic [31:0] res_s;
    int          out_cnt = 0;

    mul_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_dest    (in_dest),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_signed (mul_signed),
        .mul_resetn (mul_resetn),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the Booth/Wallace multiplier.
    logic signed [63:0] mx_a, mx_b;
    always_comb begin
        mx_a = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'h0, mul_a};
        mx_b = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'h0, mul_b};
        mul_result = mx_a * mx_b;
    end

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up = {32'h0, a} * {32'h0, b};
        case (op)
            2'b00:   return up[31:0];
            2'b01:   return sp[63:32];
            2'b10:   return up[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic [31:0] exp);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_dest  = dest;
        cur_dest = dest;
        cur_exp  = exp;
    endtask

    // One clock: sample handshakes at the falling edge, update the scoreboard,
    // then step past the rising edge.
    task automatic tick();
        logic [36:0] e;
        @(negedge clk);
        ir_s  = in_ready;
        ov_s  = out_valid;
        res_s = out_result;
        acc_s = in_valid & in_ready;
        if (out_valid && out_ready) begin
            out_cnt++;
            if (sbq.size() == 0) begin
                check("sb_unexpected", {63'h0, out_valid}, 64'h0);
            end else begin
                e = sbq.pop_front();
                check("sb_dest", {59'h0, out_dest}, {59'h0, e[36:32]});
                check("sb_result", {32'h0, out_result}, {32'h0, e[31:0]});
            end
        end
        if (acc_s) sbq.push_back({cur_dest, cur_exp});
        @(posedge clk);
        if (reset || flush) sbq.delete();
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [1:0]  op_t[4];
    logic [31:0] a_t[4];
    logic [31:0] b_t[4];
    logic [31:0] e_t[4];
    logic [31:0] held;
    int          tries;
    int          cnt0;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
        in_src1 = 32'h0; in_src2 = 32'h0; in_dest = 5'h0; out_ready = 1'b0;
        cur_dest = 5'h0; cur_exp = 32'h0;

        // Reset state
        tick(); tick();
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_out_result", {32'h0, out_result}, 64'h0);
        check("rst_out_dest", {59'h0, out_dest}, 64'h0);
        check("rst_mul_a", {32'h0, mul_a}, 64'h0);
        check("rst_mul_b", {32'h0, mul_b}, 64'h0);
        check("rst_mul_signed", {63'h0, mul_signed}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h0);
        check("rst_mul_resetn", {63'h0, mul_resetn}, 64'h0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("in_ready_idle", {63'h0, in_ready}, 64'h1);
        check("mul_resetn_run", {63'h0, mul_resetn}, 64'h1);

        // mul.w latency and value
        drive(2'b00, 32'h00000007, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
        tick();
        check("mulw_accept", {63'h0, acc_s}, 64'h1);
        in_valid = 1'b0;
        check("mulw_not_early", {63'h0, out_valid}, 64'h0);
        tick();
        check("mulw_valid", {63'h0, out_valid}, 64'h1);
        check("mulw_result", {32'h0, out_result}, {32'h0, 32'hFFFFFFEB});
        check("mulw_dest", {59'h0, out_dest}, {59'h0, 5'd5});
        idle(3);

        // Back-to-back high-word ops at full throughput
        op_t = '{2'b01, 2'b10, 2'b01, 2'b00};
        a_t  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
        b_t  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9ABCDEF0};
        e_t  = '{32'h40000000, 32'hFFFFFFFE, 32'h00000000, ref_res(2'b00, 32'h12345678, 32'h9ABCDEF0)};
        cnt0 = out_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(op_t[i], a_t[i], b_t[i], 5'(10 + i), e_t[i]);
            else in_valid = 1'b0;
            tick();
            if (i < 4) check("b2b_in_ready", {63'h0, ir_s}, 64'h1);
            if (i >= 2) check("b2b_out_valid", {63'h0, ov_s}, 64'h1);
        end
        idle(2);
        check("b2b_count", 64'(out_cnt - cnt0), 64'd4);
        check("b2b_drained", 64'(sbq.size()), 64'd0);

        // Back-pressure: 2 of 3 accepted, output held stable
        out_ready = 1'b0;
        drive(2'b10, 32'hDEADBEEF, 32'h00010000, 5'd1, ref_res(2'b10, 32'hDEADBEEF, 32'h00010000));
        tick();
        check("bp_acc_a", {63'h0, acc_s}, 64'h1);
        drive(2'b01, 32'hFFFF0000, 32'h00020000, 5'd2, ref_res(2'b01, 32'hFFFF0000, 32'h00020000));
        tick();
        check("bp_acc_b", {63'h0, acc_s}, 64'h1);
        drive(2'b00, 32'h00000003, 32'h00000005, 5'd3, 32'h0000000F);
        tick();
        held = res_s;
        check("bp_full_ready", {63'h0, ir_s}, 64'h0);
        tick();
        check("bp_full_ready2", {63'h0, ir_s}, 64'h0);
        tick();
        check("bp_full_ready3", {63'h0, ir_s}, 64'h0);
        check("bp_stable", {32'h0, res_s}, {32'h0, held});
        check("bp_stable_val", {32'h0, res_s}, {32'h0, ref_res(2'b10, 32'hDEADBEEF, 32'h00010000)});
        out_ready = 1'b1;
        tries = 0;
        do begin
            tick();
            tries++;
        end while (!acc_s && tries < 4);
        check("bp_acc_c", {63'h0, acc_s}, 64'h1);
        idle(4);
        check("bp_drained", 64'(sbq.size()), 64'd0);

        // Flush with both stages full
        out_ready = 1'b0;
        drive(2'b00, 32'h11111111, 32'h2, 5'd7, 32'h22222222);
        tick();
        drive(2'b00, 32'h33333333, 32'h2, 5'd8, 32'h66666666);
        tick();
        drive(2'b00, 32'h44444444, 32'h2, 5'd9, 32'h88888888);
        flush = 1'b1;
        tick();
        check("flush_in_ready", {63'h0, ir_s}, 64'h0);
        check("flush_no_accept", {63'h0, acc_s}, 64'h0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_out_valid", {63'h0, out_valid}, 64'h0);
        cnt0 = out_cnt;
        idle(4);
        check("flush_no_results", 64'(out_cnt - cnt0), 64'd0);

        // Reserved op
        drive(2'b11, 32'h00000005, 32'h00000006, 5'd3, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        check("rsvd_valid", {63'h0, out_valid}, 64'h1);
        check("rsvd_result", {32'h0, out_result}, 64'h0);
        idle(2);

        // Reset mid-stream
        drive(2'b00, 32'hCAFEF00D, 32'h00000003, 5'd12, ref_res(2'b00, 32'hCAFEF00D, 32'h3));
        tick();
        drive(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd13, ref_res(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF));
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("mrst_out_valid", {63'h0, out_valid}, 64'h0);
        check("mrst_out_result", {32'h0, out_result}, 64'h0);
        check("mrst_mul_a", {32'h0, mul_a}, 64'h0);
        check("mrst_mul_b", {32'h0, mul_b}, 64'h0);
        check("mrst_mul_resetn", {63'h0, mul_resetn}, 64'h0);
        check("mrst_in_ready", {63'h0, in_ready}, 64'h0);
        reset = 1'b0;
        cnt0 = out_cnt;
        idle(3);
        check("mrst_no_results", 64'(out_cnt - cnt0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
